// File: rtl/fft_bin_magnitude.sv
// ============================================================================
// Module   : fft_bin_magnitude
// Purpose  : Streams one frame of complex FFT bins, converts each to an
//            alpha-max-plus-beta-min magnitude and commits the whole frame
//            atomically to F. Optional macro FFT_MAG_PEAK_HOLD_EN selects
//            peak hold with 1/8 decay per frame at commit time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_bin_magnitude #(
    parameter int NBINS = 16,
    parameter int IN_W  = 18,
    parameter int OUT_W = 36,
    parameter int SHIFT = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_re,
    input  logic signed [IN_W-1:0]  in_im,
    input  logic                    in_last,
    output logic signed [OUT_W-1:0] F [NBINS],
    output logic                    done,
    output logic                    frame_err
);

    localparam int IDX_W  = (NBINS > 1) ? $clog2(NBINS) : 1;
    localparam int MAG_W  = IN_W + 1;
    localparam int WIDE_W = (MAG_W + SHIFT > OUT_W) ? (MAG_W + SHIFT) : OUT_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBINS - 1);
    localparam logic [WIDE_W-1:0] SAT_MAX  =
        {{(WIDE_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               drain_q, drain_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               err_q;

    logic               v1_q, v2_q;
    logic [IDX_W-1:0]   idx1_q, idx2_q;
    logic [IN_W-1:0]    re1_q, im1_q;
    logic [OUT_W-1:0]   mag2_q;

    logic signed [OUT_W-1:0] shadow_q [NBINS];
    logic signed [OUT_W-1:0] f_q      [NBINS];
    logic signed [OUT_W-1:0] f_d      [NBINS];

    logic               w_xfer, w_is_last_idx, w_good_last, w_bad;
    logic [IN_W-1:0]    w_re_abs, w_im_abs, w_max, w_min;
    logic [MAG_W-1:0]   w_mag;
    logic [WIDE_W-1:0]  w_wide;
    logic [OUT_W-1:0]   w_sat;

    assign w_xfer        = in_valid && ready_q;
    assign w_is_last_idx = (idx_q == LAST_IDX);
    assign w_good_last   = w_xfer && in_last && w_is_last_idx;
    // A frame is malformed when in_last and the final index disagree.
    assign w_bad         = w_xfer && (in_last != w_is_last_idx);

    // Negating the most-negative code yields 2^(IN_W-1) as an unsigned value.
    assign w_re_abs = in_re[IN_W-1] ? IN_W'(-in_re) : IN_W'(in_re);
    assign w_im_abs = in_im[IN_W-1] ? IN_W'(-in_im) : IN_W'(in_im);

    assign w_max  = (re1_q >= im1_q) ? re1_q : im1_q;
    assign w_min  = (re1_q >= im1_q) ? im1_q : re1_q;
    assign w_mag  = {1'b0, w_max} + MAG_W'(w_min >> 1);
    assign w_wide = WIDE_W'(w_mag) << SHIFT;
    assign w_sat  = (w_wide > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : w_wide[OUT_W-1:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        done_d  = done_q;
        case (state_q)
            ST_ACCUM: begin
                if (w_bad) begin
                    idx_d = '0;
                end else if (w_good_last) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end else if (w_xfer) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = ST_COMMIT;
                    drain_d = 1'b0;
                end
            end
            ST_COMMIT: begin
                state_d = ST_ACCUM;
                done_d  = 1'b1;
                idx_d   = '0;
            end
            default: state_d = ST_ACCUM;
        endcase
        ready_d = (state_d == ST_ACCUM);
    end

    always_comb begin
        for (int k = 0; k < NBINS; k++) begin
`ifdef FFT_MAG_PEAK_HOLD_EN
            f_d[k] = f_q[k] - (f_q[k] >>> 3);
            if (shadow_q[k] > f_d[k]) begin
                f_d[k] = shadow_q[k];
            end
`else
            f_d[k] = shadow_q[k];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            idx_q   <= '0;
            drain_q <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= w_bad;
        end
    end

    // Two-stage magnitude pipeline; a malformed transfer squashes everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            idx1_q <= '0;
            idx2_q <= '0;
            re1_q  <= '0;
            im1_q  <= '0;
            mag2_q <= '0;
            for (int k = 0; k < NBINS; k++) begin
                shadow_q[k] <= '0;
                f_q[k]      <= '0;
            end
        end else begin
            v1_q   <= w_xfer && !w_bad;
            idx1_q <= idx_q;
            re1_q  <= w_re_abs;
            im1_q  <= w_im_abs;
            v2_q   <= v1_q && !w_bad;
            idx2_q <= idx1_q;
            mag2_q <= w_sat;
            if (v2_q && !w_bad) begin
                shadow_q[idx2_q] <= mag2_q;
            end
            if (state_q == ST_COMMIT) begin
                for (int k = 0; k < NBINS; k++) begin
                    f_q[k] <= f_d[k];
                end
            end
        end
    end

    assign F         = f_q;
    assign in_ready  = ready_q;
    assign done      = done_q;
    assign frame_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_bin_magnitude.sv
// ============================================================================
// Module   : tb_fft_bin_magnitude
// Purpose  : Self-checking bench; three instances (SHIFT 0/17/18) share one
//            stimulus stream and are compared against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_bin_magnitude;

    localparam longint SAT = 64'd34359738367;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic signed [17:0] in_re = '0;
    logic signed [17:0] in_im = '0;
    logic rdy [3];
    logic done_o [3];
    logic err_o [3];
    logic signed [35:0] fa [16];
    logic signed [35:0] fb [16];
    logic signed [35:0] fc [16];
    logic signed [35:0] f_all [3][16];

    int tests = 0;
    int failed = 0;
    int sh_tab [3] = '{0, 17, 18};
    int fr_re [16];
    int fr_im [16];
    longint exp_f [3][16];
    bit exp_done = 1'b0;

    always #5 clk = ~clk;

    fft_bin_magnitude #(.NBINS(16), .IN_W(18), .OUT_W(36), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .F(fa), .done(done_o[0]), .frame_err(err_o[0]));
    fft_bin_magnitude #(.NBINS(16), .IN_W(18), .OUT_W(36), .SHIFT(17)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .F(fb), .done(done_o[1]), .frame_err(err_o[1]));
    fft_bin_magnitude #(.NBINS(16), .IN_W(18), .OUT_W(36), .SHIFT(18)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .F(fc), .done(done_o[2]), .frame_err(err_o[2]));

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            f_all[0][k] = fa[k];
            f_all[1][k] = fb[k];
            f_all[2][k] = fc[k];
        end
    end

    // Reference magnitude: |a| and |b| in plain integers, max + floor(min/2), scaled and clipped.
    function automatic longint model_mag(input int re, input int im, input int sh);
        longint a, b, m, v;
        a = (re < 0) ? -longint'(re) : longint'(re);
        b = (im < 0) ? -longint'(im) : longint'(im);
        m = (a > b) ? a + b / 2 : b + a / 2;
        v = m * (longint'(1) << sh);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic model_commit();
        longint n, d;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 16; k++) begin
                n = model_mag(fr_re[k], fr_im[k], sh_tab[i]);
`ifdef FFT_MAG_PEAK_HOLD_EN
                d = exp_f[i][k] - exp_f[i][k] / 8;
                if (d > n) n = d;
`else
                d = 0;
`endif
                exp_f[i][k] = n;
            end
        end
        exp_done = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 16; k++) exp_f[i][k] = 0;
        exp_done = 1'b0;
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(262143)) - 131072;
    endfunction

    task automatic rand_frame();
        for (int k = 0; k < 16; k++) begin
            fr_re[k] = rand_sample();
            fr_im[k] = rand_sample();
        end
    endtask

    task automatic xfer(input int re, input int im, input bit last, input bit gaps);
        int guard;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
        end
        in_re = 18'(re);
        in_im = 18'(im);
        in_last = last;
        in_valid = 1'b1;
        guard = 0;
        while (!rdy[0] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!rdy[0]) begin
            tests++; failed++;
            $display("FAIL handshake_timeout in_ready got %0b required 1", rdy[0]);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int k = 0; k < 16; k++) xfer(fr_re[k], fr_im[k], (k == 15), gaps);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 16; k++) begin
                tests++;
                if (f_all[i][k] !== 36'sd0) begin
                    failed++; $display("FAIL reset_F[%0d][%0d] got %0d required 0", i, k, f_all[i][k]);
                end
            end
            tests++;
            if ({done_o[i], err_o[i], rdy[i]} !== 3'b000) begin
                failed++; $display("FAIL reset_ctl[%0d] done/err/rdy got %b required 000", i, {done_o[i], err_o[i], rdy[i]});
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        tests++;
        if (rdy[0] !== 1'b0) begin failed++; $display("FAIL reset_rdy_before_edge got %b required 0", rdy[0]); end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rdy[i] !== 1'b1) begin failed++; $display("FAIL reset_rdy_after_edge[%0d] got %b required 1", i, rdy[i]); end
        end
    endtask

    task automatic test_basic_frame();
        for (int k = 0; k < 16; k++) begin fr_re[k] = k; fr_im[k] = 0; end
        send_frame(1'b0);
        for (int s = 0; s < 3; s++) begin
            tests++;
            if (rdy[0] !== 1'b0 || done_o[0] !== 1'b0) begin
                failed++; $display("FAIL basic_drain step %0d rdy/done got %b%b required 00", s, rdy[0], done_o[0]);
            end
            @(posedge clk); #1;
        end
        model_commit();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rdy[i] !== 1'b1 || done_o[i] !== 1'b1) begin
                failed++; $display("FAIL basic_commit[%0d] rdy/done got %b%b required 11", i, rdy[i], done_o[i]);
            end
            for (int k = 0; k < 16; k++) begin
                tests++;
                if (f_all[i][k] !== 36'(exp_f[i][k])) begin
                    failed++; $display("FAIL basic_F[%0d][%0d] got %0d required %0d", i, k, f_all[i][k], exp_f[i][k]);
                end
            end
        end
        tests++;
        if (fa[15] !== 36'sd15) begin failed++; $display("FAIL basic_F15_shift0 got %0d required 15", fa[15]); end
    endtask

    task automatic test_arithmetic();
        rand_frame();
        fr_re[0] = -131072; fr_im[0] = -131072;
        fr_re[1] = 3;       fr_im[1] = -4;
        send_frame(1'b0);
        repeat (3) @(posedge clk);
        #1;
        model_commit();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 16; k++) begin
                tests++;
                if (f_all[i][k] !== 36'(exp_f[i][k])) begin
                    failed++; $display("FAIL arith_F[%0d][%0d] got %0d required %0d", i, k, f_all[i][k], exp_f[i][k]);
                end
            end
        end
        tests++;
        if (fa[1] !== 36'sd5) begin failed++; $display("FAIL arith_3_m4 got %0d required 5", fa[1]); end
        tests++;
        if (fb[0] !== 36'sd25769803776) begin failed++; $display("FAIL arith_minneg_shift17 got %0d required 25769803776", fb[0]); end
        tests++;
        if (fc[0] !== 36'sd34359738367) begin failed++; $display("FAIL arith_saturate_shift18 got %0d required 34359738367", fc[0]); end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send_frame(1'b0);
            model_commit();
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 16; k++) begin
                tests++;
                if (f_all[i][k] !== 36'(exp_f[i][k])) begin
                    failed++; $display("FAIL b2b_F[%0d][%0d] got %0d required %0d", i, k, f_all[i][k], exp_f[i][k]);
                end
            end
        end
    endtask

    task automatic test_malformed();
        int nb;
        for (int c = 0; c < 2; c++) begin
            nb = (c == 0) ? 10 : 16;
            for (int b = 0; b < nb; b++) xfer(rand_sample(), rand_sample(), (c == 0 && b == 9), 1'b0);
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (err_o[i] !== 1'b1 || rdy[i] !== 1'b1 || done_o[i] !== exp_done) begin
                    failed++; $display("FAIL malformed%0d_pulse[%0d] err/rdy/done got %b%b%b required 11%b", c, i, err_o[i], rdy[i], done_o[i], exp_done);
                end
                for (int k = 0; k < 16; k++) begin
                    tests++;
                    if (f_all[i][k] !== 36'(exp_f[i][k])) begin
                        failed++; $display("FAIL malformed%0d_F[%0d][%0d] got %0d required %0d", c, i, k, f_all[i][k], exp_f[i][k]);
                    end
                end
            end
            @(posedge clk); #1;
            tests++;
            if (err_o[0] !== 1'b0) begin failed++; $display("FAIL malformed%0d_pulse_width got %b required 0", c, err_o[0]); end
            rand_frame();
            send_frame(1'b0);
            repeat (3) @(posedge clk);
            #1;
            model_commit();
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 16; k++) begin
                    tests++;
                    if (f_all[i][k] !== 36'(exp_f[i][k])) begin
                        failed++; $display("FAIL malformed%0d_recover_F[%0d][%0d] got %0d required %0d", c, i, k, f_all[i][k], exp_f[i][k]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int f = 0; f < 2; f++) begin
            rand_frame();
            send_frame(1'b1);
            repeat (3) @(posedge clk);
            #1;
            model_commit();
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 16; k++) begin
                    tests++;
                    if (f_all[i][k] !== 36'(exp_f[i][k])) begin
                        failed++; $display("FAIL bp%0d_F[%0d][%0d] got %0d required %0d", f, i, k, f_all[i][k], exp_f[i][k]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        rand_frame();
        for (int k = 0; k < 8; k++) xfer(fr_re[k], fr_im[k], 1'b0, 1'b0);
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({done_o[i], err_o[i], rdy[i]} !== 3'b000) begin
                failed++; $display("FAIL midrst_ctl[%0d] done/err/rdy got %b required 000", i, {done_o[i], err_o[i], rdy[i]});
            end
            for (int k = 0; k < 16; k++) begin
                tests++;
                if (f_all[i][k] !== 36'sd0) begin
                    failed++; $display("FAIL midrst_F[%0d][%0d] got %0d required 0", i, k, f_all[i][k]);
                end
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (done_o[i] !== 1'b0 || f_all[i][0] !== 36'sd0 || f_all[i][7] !== 36'sd0) begin
                failed++; $display("FAIL midrst_no_commit[%0d] done got %b F0 %0d F7 %0d required 0", i, done_o[i], f_all[i][0], f_all[i][7]);
            end
        end
    endtask

    task automatic test_commit_policy();
        longint second;
`ifdef FFT_MAG_PEAK_HOLD_EN
        second = 700;
`else
        second = 0;
`endif
        pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++) begin fr_re[k] = (f == 0) ? 800 : 0; fr_im[k] = 0; end
            send_frame(1'b0);
            repeat (3) @(posedge clk);
            #1;
            model_commit();
            for (int k = 0; k < 16; k++) begin
                tests++;
                if (fa[k] !== 36'((f == 0) ? 800 : second)) begin
                    failed++; $display("FAIL policy%0d_F0[%0d] got %0d required %0d", f, k, fa[k], (f == 0) ? 800 : second);
                end
                tests++;
                if (fb[k] !== 36'(exp_f[1][k])) begin
                    failed++; $display("FAIL policy%0d_F1[%0d] got %0d required %0d", f, k, fb[k], exp_f[1][k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_arithmetic();
        test_back_to_back();
        test_malformed();
        test_backpressure();
        test_reset_mid_frame();
        test_commit_policy();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
